sdram_wb_bridge: RTL
====================

Name: sdram_wb_bridge

Overview:
- Registered bridge between the 16-bit system-bus SDRAM port (stb/we/sel/adr/ack) and the sdram_top controller request/acknowledge interface.
- Sits directly upstream of the SDRAM controller in the board interface module.
- Replaces the ad-hoc strobe gating, DQM latching, reset stretcher and ack-delay logic with one FSM that has abort and timeout handling.
- Sits between the system bus and the controller.

Parameters:
- ADDR_W, 21: system word-address width (bits [ADDR_W:1]).
- RST_DELAY, 3: clk cycles that ctl_rst_n stays low after rst deasserts (synchronised).
- ACK_DELAY, 1: clk cycles between the controller ack and wb_ack; 0 is legal.
- TIMEOUT, 255: maximum clk cycles in REQ before forced completion; 8-bit counter.

Ports:
- clk  in  1  bus clock (100 MHz direct phase)
- rst  in  1  reset
- wb_stb  in  1  transaction strobe
- wb_we  in  1  1 = write
- wb_sel  in  2  byte selects, [1] = high byte
- wb_adr  in  ADDR_W  word address, bits [ADDR_W:1]
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data
- wb_ack  out  1  transaction acknowledge
- mem_ready  out  1  registered copy of ctl_init_done
- ctl_rst_n  out  1  controller reset, active low
- ctl_wr_req  out  1  write request
- ctl_rd_req  out  1  read request
- ctl_wr_ack  in  1  write acknowledge pulse
- ctl_rd_ack  in  1  read acknowledge pulse
- ctl_init_done  in  1  controller initialisation complete
- ctl_addr  out  ADDR_W+1  {1'b0, latched address}
- ctl_wdata  out  16  latched write data
- ctl_rdata  in  16  controller read data
- ctl_be  out  2  latched byte enables
- dqm_h  out  1  SDRAM UDQM
- dqm_l  out  1  SDRAM LDQM
- timeout  out  1  sticky timeout flag

Behaviour:
- Single clock clk. Reset rst is asynchronous, active-high.
- Reset values: every output 0, wb_dat_o = 16'h0000, ctl_rst_n = 0, FSM = IDLE.
- ctl_rst_n:
  - rst passes through a 2-flop synchroniser, then a RST_DELAY counter.
  - ctl_rst_n rises RST_DELAY+2 cycles after rst falls.
  - Any rst reassertion drops it immediately.
- FSM states: IDLE, REQ, HOLD, ACK, DRAIN.
- IDLE:
  - If wb_stb=1 and mem_ready=1: latch adr, dat_i, we, sel.
  - dqm_h/dqm_l = we ? ~sel[1]/~sel[0] : 0/0 (reads are always full word).
  - Assert ctl_wr_req or ctl_rd_req on the next edge; go to REQ.
  - With wb_stb=1 and mem_ready=0, wait in IDLE with no ack.
- REQ:
  - The request is held until the matching ack: ctl_wr_ack for writes, ctl_rd_ack for reads.
  - An ack for the other direction is ignored.
  - On the matching ack: drop the request the same edge and capture ctl_rdata into wb_dat_o on reads (writes leave wb_dat_o unchanged).
  - Then go to HOLD (ACK_DELAY>0) or straight to ACK.
  - If wb_stb is seen low while in REQ, set an abort bit. The request still completes because the controller cannot cancel.
- HOLD: counts ACK_DELAY cycles, then goes to ACK, or to DRAIN if the abort bit is set.
- ACK: wb_ack = wb_stb (combinational gate on the registered state). When wb_stb=0, go to IDLE.
- DRAIN: no ack; go to IDLE next cycle and clear the abort bit.
- Timeout:
  - The REQ counter increments every cycle.
  - On reaching TIMEOUT: drop the request, set timeout=1 (cleared only by rst), load wb_dat_o = 16'hFFFF on reads, and go to ACK so the bus never hangs.
- Latency, read with ACK_DELAY=1 and an immediate controller ack: stb seen at edge 0, req at edge 1, ack sampled at edge 2 (N), wb_ack high after edge N+1.
- Back-to-back: a new wb_stb is accepted only from IDLE, so there is at least one idle cycle between transactions.
- mem_ready falling mid-transaction does not affect the current transaction.

Optional Feature:
- Macro: SDRAM_RDBUF_EN.
- Enabled:
  - One-entry read buffer (address, data, valid).
  - A read in IDLE whose address matches a valid entry skips REQ, loads wb_dat_o from the buffer and goes to ACK (ack after 1 cycle).
  - A completed controller read fills the buffer.
  - Any write to the same address updates the buffer bytes selected by sel. A write to any other address leaves it untouched.
  - rst or mem_ready=0 invalidates the buffer.
- Disabled: every read goes to the controller; no buffer flops exist.

Decomposition:
- Shared package sdram_bridge_pkg holds:
  - FSM state enum (IDLE=0, REQ=1, HOLD=2, ACK=3, DRAIN=4).
  - Default constants for RST_DELAY, ACK_DELAY, TIMEOUT.
  - Timeout read data 16'hFFFF.
- One natural sub-module: sdram_rst_stretch (synchroniser plus RST_DELAY counter producing ctl_rst_n).

Test Plan:
- Reset release: rst deasserted at cycle 0 -> ctl_rst_n=1 at cycle 5 (RST_DELAY=3); rst pulse at cycle 10 -> ctl_rst_n=0 same cycle.
- Word read, adr 21'h000100, controller returns 16'h1234 with rd_ack 4 cycles after req -> ctl_addr=22'h000100, dqm 0/0, wb_dat_o=16'h1234, one wb_ack window, rd_req low after ack.
- Byte write: sel=2'b10, dat 16'hAB00, adr 21'h1FFFFF -> ctl_wr_req, dqm_h=0, dqm_l=1, ctl_be=2'b10, ctl_addr=22'h1FFFFF, wb_ack after wr_ack+ACK_DELAY.
- Abort: wb_stb dropped 1 cycle after req; controller acks 6 cycles later -> req held until ack, no wb_ack, FSM back in IDLE, next read works.
- Timeout: controller never acks a read -> after 255 cycles req drops, timeout=1, wb_dat_o=16'hFFFF, wb_ack asserted; timeout stays 1 until rst.
- With SDRAM_RDBUF_EN: read 21'h40 -> 16'h5555; byte write sel=01 16'h00AA to the same adr; reread -> 16'h55AA with no ctl_rd_req pulse.

Source files
------------

// File: rtl/sdram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_bridge_pkg
// Description : Shared state encoding and default constants for the
//               system-bus to SDRAM controller bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        HOLD  = 3'd2,
        ACK   = 3'd3,
        DRAIN = 3'd4
    } bridge_state_t;

    localparam int unsigned c_rst_delay_dflt = 3;
    localparam int unsigned c_ack_delay_dflt = 1;
    localparam int unsigned c_timeout_dflt   = 255;

    // Read data returned to the bus when the controller never answers
    localparam logic [15:0] c_timeout_rdata = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/sdram_rst_stretch.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rst_stretch
// Description : Synchronises rst release and holds ctl_rst_n low for a
//               further RST_DELAY cycles; reassertion drops it at once.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_rst_stretch
    import sdram_bridge_pkg::*;
#(
    parameter int unsigned RST_DELAY = c_rst_delay_dflt
) (
    input  logic clk,
    input  logic rst,
    output logic ctl_rst_n
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    generate
        if (RST_DELAY == 0) begin : g_no_delay
            assign ctl_rst_n = r_sync[1];
        end else begin : g_delay
            localparam int unsigned c_cnt_w = (RST_DELAY > 1) ? $clog2(RST_DELAY) : 1;
            localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(RST_DELAY - 1);

            logic [c_cnt_w-1:0] r_cnt;
            logic               r_rst_n;

            // The release edge itself is the last counted cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_rst_n <= 1'b0;
                end else if (r_sync[1] && !r_rst_n) begin
                    if (r_cnt == c_cnt_last) begin
                        r_rst_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign ctl_rst_n = r_rst_n;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sdram_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : sdram_wb_bridge
// Description : Registered 16-bit system-bus to SDRAM controller bridge with
//               abort and timeout handling. Optional one-entry read buffer
//               is built when SDRAM_RDBUF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_wb_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W    = 21,
    parameter int unsigned RST_DELAY = c_rst_delay_dflt,
    parameter int unsigned ACK_DELAY = c_ack_delay_dflt,
    parameter int unsigned TIMEOUT   = c_timeout_dflt
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [1:0]        wb_sel,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [15:0]       wb_dat_i,
    output logic [15:0]       wb_dat_o,
    output logic              wb_ack,
    output logic              mem_ready,
    output logic              ctl_rst_n,
    output logic              ctl_wr_req,
    output logic              ctl_rd_req,
    input  logic              ctl_wr_ack,
    input  logic              ctl_rd_ack,
    input  logic              ctl_init_done,
    output logic [ADDR_W:0]   ctl_addr,
    output logic [15:0]       ctl_wdata,
    input  logic [15:0]       ctl_rdata,
    output logic [1:0]        ctl_be,
    output logic              dqm_h,
    output logic              dqm_l,
    output logic              timeout
);

    localparam logic [7:0] c_to_last   = 8'(TIMEOUT - 1);
    localparam logic [7:0] c_hold_last = 8'(ACK_DELAY - 1);

    bridge_state_t     r_state;
    logic              r_we;
    logic              r_abort;
    logic [7:0]        r_cnt;
    logic              r_mem_ready;
    logic              r_timeout;
    logic              r_wr_req;
    logic              r_rd_req;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic [1:0]        r_be;
    logic              r_dqm_h;
    logic              r_dqm_l;
    logic [15:0]       r_dat_o;

    logic              w_match;
    logic              w_req_to;
    logic              w_buf_hit;
    logic [15:0]       w_buf_dat;

    sdram_rst_stretch #(
        .RST_DELAY (RST_DELAY)
    ) u_rst_stretch (
        .clk       (clk),
        .rst       (rst),
        .ctl_rst_n (ctl_rst_n)
    );

    // Only the ack for the direction in flight can complete the request
    assign w_match  = r_we ? ctl_wr_ack : ctl_rd_ack;
    assign w_req_to = !w_match && (r_cnt == c_to_last);

`ifdef SDRAM_RDBUF_EN
    logic [ADDR_W-1:0] r_buf_adr;
    logic [15:0]       r_buf_dat;
    logic              r_buf_vld;

    assign w_buf_hit = r_buf_vld && !wb_we && (r_buf_adr == wb_adr);
    assign w_buf_dat = r_buf_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_adr <= '0;
            r_buf_dat <= 16'h0000;
            r_buf_vld <= 1'b0;
        end else if (!r_mem_ready) begin
            r_buf_vld <= 1'b0;
        end else if (r_state == REQ) begin
            if (w_match && !r_we) begin
                r_buf_adr <= r_addr;
                r_buf_dat <= ctl_rdata;
                r_buf_vld <= 1'b1;
            end else if (w_match && (r_buf_adr == r_addr)) begin
                if (r_be[1]) r_buf_dat[15:8] <= r_wdata[15:8];
                if (r_be[0]) r_buf_dat[7:0]  <= r_wdata[7:0];
            end else if (w_req_to) begin
                // A timed-out write may or may not have landed
                r_buf_vld <= 1'b0;
            end
        end
    end
`else
    assign w_buf_hit = 1'b0;
    assign w_buf_dat = 16'h0000;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_abort     <= 1'b0;
            r_cnt       <= 8'd0;
            r_mem_ready <= 1'b0;
            r_timeout   <= 1'b0;
            r_wr_req    <= 1'b0;
            r_rd_req    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 16'h0000;
            r_be        <= 2'b00;
            r_dqm_h     <= 1'b0;
            r_dqm_l     <= 1'b0;
            r_dat_o     <= 16'h0000;
        end else begin
            r_mem_ready <= ctl_init_done;
            case (r_state)
                IDLE: begin
                    if (wb_stb && r_mem_ready) begin
                        r_we    <= wb_we;
                        r_addr  <= wb_adr;
                        r_wdata <= wb_dat_i;
                        r_be    <= wb_sel;
                        r_dqm_h <= wb_we & ~wb_sel[1];
                        r_dqm_l <= wb_we & ~wb_sel[0];
                        r_abort <= 1'b0;
                        r_cnt   <= 8'd0;
                        if (w_buf_hit) begin
                            r_dat_o <= w_buf_dat;
                            r_state <= ACK;
                        end else begin
                            r_wr_req <= wb_we;
                            r_rd_req <= ~wb_we;
                            r_state  <= REQ;
                        end
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (!wb_stb) begin
                        r_abort <= 1'b1;
                    end
                    if (w_match) begin
                        r_wr_req <= 1'b0;
                        r_rd_req <= 1'b0;
                        r_cnt    <= 8'd0;
                        if (!r_we) begin
                            r_dat_o <= ctl_rdata;
                        end
                        if (ACK_DELAY != 0) begin
                            r_state <= HOLD;
                        end else begin
                            r_state <= (r_abort || !wb_stb) ? DRAIN : ACK;
                        end
                    end else if (w_req_to) begin
                        r_wr_req  <= 1'b0;
                        r_rd_req  <= 1'b0;
                        r_timeout <= 1'b1;
                        r_cnt     <= 8'd0;
                        if (!r_we) begin
                            r_dat_o <= c_timeout_rdata;
                        end
                        // An aborted master is no longer waiting, so no ack is owed
                        r_state <= (r_abort || !wb_stb) ? DRAIN : ACK;
                    end
                end
                HOLD: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == c_hold_last) begin
                        r_state <= r_abort ? DRAIN : ACK;
                    end
                end
                ACK: begin
                    if (!wb_stb) begin
                        r_state <= IDLE;
                    end
                end
                DRAIN: begin
                    r_abort <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wb_ack     = (r_state == ACK) && wb_stb;
    assign wb_dat_o   = r_dat_o;
    assign mem_ready  = r_mem_ready;
    assign ctl_wr_req = r_wr_req;
    assign ctl_rd_req = r_rd_req;
    assign ctl_addr   = {1'b0, r_addr};
    assign ctl_wdata  = r_wdata;
    assign ctl_be     = r_be;
    assign dqm_h      = r_dqm_h;
    assign dqm_l      = r_dqm_l;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire
